// File: rtl/mamba_acc_pkg.sv
`default_nettype none
// ============================================================================
// Package : mamba_acc_pkg
// Shared widths, FSM states and the saturating narrow helper for the MAC path.
// Rev     : 1.0
// ============================================================================
package mamba_acc_pkg;

  localparam int ACC_DATA_W = 16;
  localparam int ACC_TILE_N = 16;
  localparam int ACC_ACC_W  = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCUM  = 2'd1,
    ST_OUTPUT = 2'd2
  } acc_state_e;

  typedef struct packed {
    logic                  clip;
    logic [ACC_DATA_W-1:0] val;
  } sat_res_t;

  // A value fits iff every bit from the sign down to the narrow MSB agrees.
  function automatic sat_res_t sat_narrow(input logic [ACC_ACC_W-1:0] acc);
    sat_res_t                         r;
    logic [ACC_ACC_W-ACC_DATA_W:0]    top;
    top    = acc[ACC_ACC_W-1:ACC_DATA_W-1];
    r.clip = !((top == '0) || (&top));
    if (!r.clip)
      r.val = acc[ACC_DATA_W-1:0];
    else if (acc[ACC_ACC_W-1])
      r.val = {1'b1, {(ACC_DATA_W-1){1'b0}}};
    else
      r.val = {1'b0, {(ACC_DATA_W-1){1'b1}}};
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/psum_tile_accumulator_if.sv
`default_nettype none
// ============================================================================
// Interface : psum_tile_accumulator_if
// Psum input stream and final-vector output stream of the tile accumulator.
// Rev       : 1.0
// ============================================================================
interface psum_tile_accumulator_if
  import mamba_acc_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_DATA_W,
  parameter int TILE_SIZE  = ACC_TILE_N
);
  logic                                in_valid;
  logic                                in_ready;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] psum_in;
  logic                                out_valid;
  logic                                out_ready;
  logic [TILE_SIZE-1:0][DATA_WIDTH-1:0] out_data;
  logic [TILE_SIZE-1:0]                out_sat;

  modport master (
    output in_valid, psum_in, out_ready,
    input  in_ready, out_valid, out_data, out_sat
  );

  modport slave (
    input  in_valid, psum_in, out_ready,
    output in_ready, out_valid, out_data, out_sat
  );
endinterface
`default_nettype wire

// File: rtl/psum_acc_lane.sv
`default_nettype none
// ============================================================================
// Module : psum_acc_lane
// One lane: wide wrapping accumulator, load/add select, saturating capture.
// Rev    : 1.0
// ============================================================================
module psum_acc_lane
  import mamba_acc_pkg::*;
#(
  parameter int DATA_WIDTH = ACC_DATA_W,
  parameter int ACC_WIDTH  = ACC_ACC_W
) (
  input  wire                  clk,
  input  wire                  rst_n,
  input  wire                  i_beat,
  input  wire                  i_first,
  input  wire                  i_capture,
  input  wire [DATA_WIDTH-1:0] i_psum,
  output logic [DATA_WIDTH-1:0] o_data,
  output logic                 o_sat
);
  logic signed [ACC_WIDTH-1:0] r_acc;
  logic signed [ACC_WIDTH-1:0] w_psum_ext;
  logic signed [ACC_WIDTH-1:0] w_acc_nxt;
  sat_res_t                    w_sat;

  assign w_psum_ext = ACC_WIDTH'($signed(i_psum));
  assign w_acc_nxt  = i_first ? w_psum_ext : r_acc + w_psum_ext;
  // Capture from the next-state sum so the final beat lands in the output.
  assign w_sat      = sat_narrow(ACC_ACC_W'(w_acc_nxt));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc  <= '0;
      o_data <= '0;
      o_sat  <= 1'b0;
    end else begin
      if (i_beat)
        r_acc <= w_acc_nxt;
      if (i_capture) begin
        o_data <= DATA_WIDTH'(w_sat.val);
        o_sat  <= w_sat.clip;
      end
    end
  end
endmodule
`default_nettype wire

// File: rtl/psum_tile_accumulator.sv
`default_nettype none
// ============================================================================
// Module : psum_tile_accumulator
// Accumulates K-tile psum vectors and emits one saturated vector per start.
// Rev    : 1.0
// ============================================================================
module psum_tile_accumulator
  import mamba_acc_pkg::*;
#(
  parameter int DATA_WIDTH  = ACC_DATA_W,
  parameter int TILE_SIZE   = ACC_TILE_N,
  parameter int ACC_WIDTH   = ACC_ACC_W,
  parameter int MAX_K_TILES = 64,
  parameter int KCNT_W      = $clog2(MAX_K_TILES + 1)
) (
  input  wire                     clk,
  input  wire                     rst_n,
  input  wire                     i_start,
  input  wire [KCNT_W-1:0]        i_k_tiles,
  output logic                    o_busy,
  output logic                    o_err_drop,
  psum_tile_accumulator_if.slave  io_bus
);
  acc_state_e        r_state;
  acc_state_e        w_state_nxt;
  logic [KCNT_W-1:0] r_cnt;
  logic [KCNT_W-1:0] r_k_lat;
  logic [KCNT_W-1:0] w_k_clamp;
  logic              r_in_ready;
  logic              r_out_valid;
  logic              w_beat;
  logic              w_last;

  wire [TILE_SIZE-1:0][DATA_WIDTH-1:0] w_out_data;
  wire [TILE_SIZE-1:0]                 w_out_sat;

  assign w_k_clamp = (i_k_tiles == '0) ? KCNT_W'(1) :
                     (i_k_tiles > KCNT_W'(MAX_K_TILES)) ? KCNT_W'(MAX_K_TILES) : i_k_tiles;
  assign w_beat    = io_bus.in_valid & r_in_ready;
  assign w_last    = (r_cnt == r_k_lat - KCNT_W'(1));

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (i_start) w_state_nxt = ST_ACCUM;
      ST_ACCUM:  if (w_beat && w_last) w_state_nxt = ST_OUTPUT;
      ST_OUTPUT: if (r_out_valid && io_bus.out_ready) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  // Handshake flags are registered from the next state so they track r_state exactly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_k_lat     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
      o_busy      <= 1'b0;
      o_err_drop  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_in_ready  <= (w_state_nxt == ST_ACCUM);
      r_out_valid <= (w_state_nxt == ST_OUTPUT);
      o_busy      <= (w_state_nxt != ST_IDLE);
      o_err_drop  <= io_bus.in_valid & ~r_in_ready;
      if (r_state == ST_IDLE) begin
        r_cnt <= '0;
        if (i_start)
          r_k_lat <= w_k_clamp;
      end else if (w_beat) begin
        r_cnt <= r_cnt + KCNT_W'(1);
      end
    end
  end

  for (genvar g = 0; g < TILE_SIZE; g++) begin : g_lane
    psum_acc_lane #(
      .DATA_WIDTH (DATA_WIDTH),
      .ACC_WIDTH  (ACC_WIDTH)
    ) u_lane (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_beat    (w_beat),
      .i_first   (r_cnt == '0),
      .i_capture (w_beat & w_last),
      .i_psum    (io_bus.psum_in[g]),
      .o_data    (w_out_data[g]),
      .o_sat     (w_out_sat[g])
    );
  end

  assign io_bus.in_ready  = r_in_ready;
  assign io_bus.out_valid = r_out_valid;
  assign io_bus.out_data  = w_out_data;
  assign io_bus.out_sat   = w_out_sat;
endmodule
`default_nettype wire

// File: tb/tb_psum_tile_accumulator.sv
`default_nettype none
// ============================================================================
// Module : tb_psum_tile_accumulator
// Directed and randomized vectors against a sum/wrap/saturate reference model.
// Rev    : 1.0
// ============================================================================
module tb_psum_tile_accumulator;
  localparam int DW   = 16;
  localparam int TN   = 16;
  localparam int AW   = 24;
  localparam int MAXK = 64;
  localparam int KW   = 7;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          i_start = 1'b0;
  logic [KW-1:0] i_k_tiles = '0;
  logic          o_busy;
  logic          o_err_drop;

  int checks = 0;
  int failures = 0;
  int beats[128][TN];

  psum_tile_accumulator_if #(.DATA_WIDTH(DW), .TILE_SIZE(TN)) bus ();

  psum_tile_accumulator #(
    .DATA_WIDTH(DW), .TILE_SIZE(TN), .ACC_WIDTH(AW), .MAX_K_TILES(MAXK), .KCNT_W(KW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_start    (i_start),
    .i_k_tiles  (i_k_tiles),
    .o_busy     (o_busy),
    .o_err_drop (o_err_drop),
    .io_bus     (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] got, input logic signed [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: exact sum, wrapped to the accumulator width, then clipped to the output range.
  function automatic int model_lane(input int k, input int l, output bit sat);
    longint s = 0;
    for (int b = 0; b < k; b++) s += beats[b][l];
    s = s & 64'hFF_FFFF;
    if (s >= (64'sd1 <<< (AW - 1))) s -= (64'sd1 <<< AW);
    sat = 1'b0;
    if (s > 32767)  begin sat = 1'b1; return 32767;  end
    if (s < -32768) begin sat = 1'b1; return -32768; end
    return int'(s);
  endfunction

  task automatic check_out(input string nm, input int exp_d[TN], input bit exp_s[TN]);
    for (int l = 0; l < TN; l++) begin
      check($sformatf("%s_d%0d", nm, l), $signed(bus.out_data[l]), exp_d[l]);
      check($sformatf("%s_s%0d", nm, l), bus.out_sat[l], exp_s[l]);
    end
  endtask

  task automatic do_vector(input string nm, input int k_req, input int n_wait,
                           input bit drops, input bit gaps, input bit poke, input bit start_hs);
    int k_eff;
    int exp_d[TN];
    bit exp_s[TN];
    bit drv_iv;
    k_eff = (k_req == 0) ? 1 : ((k_req > MAXK) ? MAXK : k_req);
    for (int l = 0; l < TN; l++) exp_d[l] = model_lane(k_eff, l, exp_s[l]);

    i_start = 1'b1; i_k_tiles = KW'(k_req);
    step();
    i_start = 1'b0;
    check({nm, "_busy_acc"}, o_busy, 1);
    check({nm, "_rdy_acc"}, bus.in_ready, 1);

    for (int b = 0; b < k_eff; b++) begin
      if (gaps || (poke && b == 0)) begin
        int ng = (poke && b == 0) ? 1 : int'($urandom_range(0, 2));
        for (int g = 0; g < ng; g++) begin
          bus.in_valid = 1'b0;
          if (poke && b == 0 && g == 0) begin i_start = 1'b1; i_k_tiles = KW'(1); end
          step();
          i_start = 1'b0;
          check({nm, "_rdy_gap"}, bus.in_ready, 1);
          check({nm, "_ov_gap"}, bus.out_valid, 0);
        end
      end
      bus.in_valid = 1'b1;
      for (int l = 0; l < TN; l++) bus.psum_in[l] = DW'(beats[b][l]);
      step();
      if (b < k_eff - 1) check({nm, "_ov_early"}, bus.out_valid, 0);
    end
    bus.in_valid = 1'b0;

    for (int w = 0; w <= n_wait; w++) begin
      check({nm, "_ov"}, bus.out_valid, 1);
      check({nm, "_rdy_out"}, bus.in_ready, 0);
      check({nm, "_busy_out"}, o_busy, 1);
      check_out(nm, exp_d, exp_s);
      if (w < n_wait) begin
        drv_iv = drops && ((w % 2 == 0) || ($urandom_range(0, 1) == 1));
        bus.out_ready = 1'b0;
        bus.in_valid  = drv_iv;
        step();
        bus.in_valid = 1'b0;
        check({nm, "_err_drop"}, o_err_drop, drv_iv);
      end
    end
    bus.out_ready = 1'b1;
    i_start = start_hs; i_k_tiles = KW'(1);
    step();
    bus.out_ready = 1'b0;
    i_start = 1'b0;
    check({nm, "_ov_done"}, bus.out_valid, 0);
    check({nm, "_busy_done"}, o_busy, 0);
    check({nm, "_rdy_done"}, bus.in_ready, 0);
    check_out({nm, "_hold"}, exp_d, exp_s);
  endtask

  task automatic fill(input int k, input int v0, input int dv);
    for (int b = 0; b < k; b++)
      for (int l = 0; l < TN; l++) beats[b][l] = v0 + dv * b;
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b0; bus.psum_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ov", bus.out_valid, 0);
    check("rst_rdy", bus.in_ready, 0);
    check("rst_busy", o_busy, 0);
    check("rst_err", o_err_drop, 0);
    check("rst_data", |bus.out_data, 0);
    check("rst_sat", |bus.out_sat, 0);
    rst_n = 1'b1;
    step();

    bus.in_valid = 1'b1; step(); bus.in_valid = 1'b0;
    check("idle_err_drop", o_err_drop, 1);
    step();
    check("idle_err_clear", o_err_drop, 0);

    fill(4, 100, 100);
    do_vector("t_sum4", 4, 0, 0, 0, 0, 0);

    fill(2, 0, 0);
    beats[0][0] = 30000;  beats[1][0] = 30000;
    beats[0][1] = -30000; beats[1][1] = -30000;
    do_vector("t_sat", 2, 0, 0, 0, 0, 0);

    fill(1, 1234, 0);
    beats[0][3] = -77;
    do_vector("t_stall", 1, 5, 1, 0, 0, 0);

    fill(1, 7, 0);
    do_vector("t_k0", 0, 0, 0, 0, 0, 0);

    fill(3, 11, 5);
    do_vector("t_poke", 3, 1, 0, 0, 1, 0);

    // Asynchronous reset mid-accumulation discards everything.
    i_start = 1'b1; i_k_tiles = KW'(4);
    step();
    i_start = 1'b0;
    fill(2, 9, 0);
    for (int b = 0; b < 2; b++) begin
      bus.in_valid = 1'b1;
      for (int l = 0; l < TN; l++) bus.psum_in[l] = DW'(beats[b][l]);
      step();
    end
    rst_n = 1'b0;
    #1;
    check("arst_ov", bus.out_valid, 0);
    check("arst_busy", o_busy, 0);
    check("arst_rdy", bus.in_ready, 0);
    check("arst_data", |bus.out_data, 0);
    bus.in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();
    fill(1, 5, 0);
    do_vector("t_after_rst", 1, 0, 0, 0, 0, 0);

    fill(3, 1, 1);
    do_vector("t_b2b_a", 3, 0, 0, 0, 0, 1);
    fill(2, 10, 10);
    do_vector("t_b2b_b", 2, 0, 0, 0, 0, 0);

    for (int v = 0; v < 24; v++) begin
      int k_req;
      int k_eff;
      k_req = ($urandom_range(0, 5) == 0) ? int'($urandom_range(65, 127)) : int'($urandom_range(0, 12));
      k_eff = (k_req == 0) ? 1 : ((k_req > MAXK) ? MAXK : k_req);
      for (int b = 0; b < k_eff; b++)
        for (int l = 0; l < TN; l++)
          beats[b][l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 65535)) - 32768
                                                    : int'($urandom_range(0, 4000)) - 2000;
      do_vector($sformatf("rnd%0d", v), k_req, int'($urandom_range(0, 3)),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                (k_eff >= 2) ? 1'($urandom_range(0, 1)) : 1'b0, 1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/psum_tile_accumulator.md
Name: psum_tile_accumulator

Overview:
- Sits directly downstream of the 16x16 row-wise MAC array.
- Accepts one partial-sum vector per K-tile, and accumulates K-tiles in a wider accumulator.
- After the programmed number of K-tiles, emits the saturated final output vector (X_PROJ RAW or delta-projection result) on a valid/ready handshake to the next stage.
- Holds the array stream off (in_ready low) while the result is pending.

Parameters:
- DATA_WIDTH, 16, width of each signed psum lane in and out.
- TILE_SIZE, 16, lanes per vector.
- ACC_WIDTH, 24, internal signed accumulator width per lane.
- MAX_K_TILES, 64, maximum K-tiles per output vector.
- KCNT_W, $clog2(MAX_K_TILES+1), width of k_tiles and the beat counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; latch k_tiles and begin a new output vector
- k_tiles  in  KCNT_W  number of psum beats to accumulate
- busy  out  1  high whenever state != IDLE
- in_valid  in  1  psum_in valid (driven from the array's valid_out)
- in_ready  out  1  accumulator accepts a beat this cycle
- psum_in  in  TILE_SIZE x DATA_WIDTH signed  partial row sums of one K-tile
- out_valid  out  1  out_data holds a final vector
- out_ready  in  1  consumer accepts out_data
- out_data  out  TILE_SIZE x DATA_WIDTH signed  saturated final sums
- out_sat  out  TILE_SIZE  per-lane flag: lane saturated on narrowing
- err_drop  out  1  one-cycle pulse: in_valid seen while in_ready low

Behaviour:
- Reset (async, rst_n low) clears the following, regardless of the current state:
  - state=IDLE; accumulators, beat counter and k latch = 0.
  - out_valid, in_ready, busy, err_drop = 0; out_data and out_sat = 0.
  - A reset mid-accumulation or mid-output discards everything; no partial result is ever emitted.
- FSM states: IDLE, ACCUM, OUTPUT.
- IDLE:
  - in_ready=0.
  - start -> ACCUM next cycle.
  - k_lat = k_tiles, with 0 mapped to 1 and values > MAX_K_TILES clamped to MAX_K_TILES.
  - Beat counter = 0.
- ACCUM:
  - in_ready=1 (registered, asserted from the first ACCUM cycle).
  - Each beat with in_valid & in_ready: on the first beat (cnt==0) acc[i] <= sign-extended psum_in[i] (load, no separate clear cycle); otherwise acc[i] <= acc[i] + sign-extended psum_in[i].
  - Accumulator arithmetic wraps at ACC_WIDTH; saturation happens only at narrowing.
  - Beat counter increments per beat.
  - On the beat where cnt == k_lat-1 -> OUTPUT next cycle, and in_ready drops in that same next cycle.
- OUTPUT:
  - out_valid=1.
  - out_data[i] = acc[i] saturated to [-2^(DATA_WIDTH-1), 2^(DATA_WIDTH-1)-1], registered on entry.
  - out_sat[i]=1 iff clipping occurred for lane i.
  - out_data and out_sat are held stable while out_valid & !out_ready.
  - out_valid & out_ready -> IDLE next cycle; out_valid=0, out_data/out_sat keep their last values.
- Latency: last accepted beat in cycle N -> out_valid high in cycle N+1. With k_lat=1 and start in cycle 0, the earliest beat is accepted in cycle 1 and out_valid rises in cycle 2.
- start while busy: ignored, with no effect on the latch, counter or accumulators.
- start in the same cycle as the OUTPUT handshake: ignored. A new start is required in IDLE.
- err_drop pulses for one cycle for each cycle in which in_valid=1 and in_ready=0, in any state. The beat is discarded.
- Back-to-back vectors: minimum gap from handshake to the next ACCUM is 2 cycles (IDLE, then start).
- No combinational path from in_valid/out_ready to any output; all outputs are registered.

Decomposition:
- Shared package mamba_acc_pkg holds:
  - typedef enum of the states;
  - a sat_narrow function (ACC_WIDTH -> DATA_WIDTH, returns value and clip flag);
  - default constants for DATA_WIDTH, TILE_SIZE and ACC_WIDTH, shared with the MAC array.
- One natural sub-module, psum_acc_lane: a single lane's accumulator register, load/add mux, saturation and sat flag. It is instantiated TILE_SIZE times by generate.
- The top level keeps the FSM, counter, handshakes and err_drop.

Test Plan:
- k_tiles=4, psum_in all lanes = 100,200,300,400 on consecutive beats -> out_valid one cycle after the 4th beat, every out_data lane = 1000, out_sat = 0.
- k_tiles=2, lane0 beats 30000 then 30000, lane1 beats -30000 then -30000 -> out_data[0]=32767 with out_sat[0]=1; out_data[1]=-32768 with out_sat[1]=1; other lanes (inputs 0) = 0.
- k_tiles=1 and out_ready held low 5 cycles, with in_valid pulsed during OUTPUT:
  - out_valid stays high with data stable;
  - in_ready=0 and err_drop pulses once per offending cycle;
  - on out_ready=1 the handshake completes and busy falls the next cycle.
- k_tiles=0 -> treated as 1: a single beat of 7 yields out_data=7. A start pulse while in ACCUM is ignored; the count still completes at the original k.
- rst_n asserted after 2 of 4 beats -> immediately out_valid=0, busy=0, out_data=0. After release, start with k_tiles=1 and beat 5 -> out_data=5, with no residue from the earlier beats.
- Two vectors back-to-back (k_tiles=3, then k_tiles=2, inputs 1,2,3 then 10,20) -> out_data 6 then 30. The second accumulation loads fresh on its first beat.
